uart0_tx_sched: RTL and testbench

- Sequences the UART0 transmitter and shares it between two requesters:
  - the CPU bus, through the memory-mapped data register (offset 0x10) and status register (offset 0x14);
  - the debug/loader byte stream.
- CPU bytes are buffered in a small FIFO.
- A round-robin arbiter picks the next byte source whenever the transmitter is idle.
- Sits between the SoC bus decoder and the UART TX core.

---
 rtl/uart0_tx_sched.sv | 194 +++++++++++++++++++
 tb/tb_uart0_tx_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart0_tx_sched.sv
// uart0_tx_sched
// Shares the UART0 transmitter between the CPU bus and the debug/loader
// byte stream. CPU bytes are buffered in a small FIFO; a round-robin
// arbiter picks the next source whenever the transmitter is idle, then a
// small FSM issues a one-cycle start pulse and tracks the core's busy flag.
//
// Ports:
//   CLK, RESET        system clock, asynchronous active-high reset
//   BUS_SEL/WR/RD     register window select and strobes
//   BUS_OFS           0 = DATA register, 1 = STATUS register
//   BUS_DI            byte to transmit (DATA writes)
//   BUS_DO            registered read data (latency 1)
//   DBG_VALID/DATA    debug byte offered
//   DBG_READY         debug byte accepted this cycle (with DBG_VALID)
//   TX_START          one-cycle start pulse to the TX core
//   TX_DATA           byte for the TX core, stable for the whole frame
//   TX_BUSY           TX core shifting
module uart0_tx_sched #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUS_SEL,
  input  logic        BUS_WR,
  input  logic        BUS_RD,
  input  logic        BUS_OFS,
  input  logic [7:0]  BUS_DI,
  output logic [31:0] BUS_DO,
  input  logic        DBG_VALID,
  input  logic [7:0]  DBG_DATA,
  output logic        DBG_READY,
  output logic        TX_START,
  output logic [7:0]  TX_DATA,
  input  logic        TX_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [PTR_W:0]   L_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   L_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   L_CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] L_PTR_ZERO = PTR_W'(0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_rr_dbg_next;  // 1: debug wins the next tie
  logic             r_last_dbg;     // source of the byte currently in flight
  logic [7:0]       r_tx_data;
  logic [31:0]      r_bus_do;
  logic             r_ovf;

  logic        w_fifo_ne;
  logic        w_full;
  logic        w_grant;
  logic        w_sel_dbg;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_stat_rd;
  logic        w_done;
  logic        w_dbgact;
  logic [31:0] w_status;
  logic        w_dbg_ready;
  logic        w_tx_start;

  // Arbitration, FIFO handshakes and status word
  always_comb begin
    w_fifo_ne  = (r_count != L_CNT_ZERO);
    w_full     = (r_count == L_DEPTH);
    w_grant    = (r_state == ST_IDLE) & (w_fifo_ne | DBG_VALID);
    // Debug wins when it is the only requester or when it is its turn.
    w_sel_dbg  = DBG_VALID & (~w_fifo_ne | r_rr_dbg_next);
    w_pop      = w_grant & ~w_sel_dbg;
    w_push_req = BUS_SEL & BUS_WR & ~BUS_OFS;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    w_push     = w_push_req & (~w_full | w_pop);
    w_ovf_set  = w_push_req & w_full & ~w_pop;
    w_stat_rd  = BUS_SEL & BUS_RD & BUS_OFS;
    w_done     = ~w_fifo_ne & (r_state == ST_IDLE) & ~DBG_VALID;
    w_dbgact   = (r_state != ST_IDLE) & r_last_dbg;
    w_status   = {27'd0, r_ovf, w_dbgact, w_full, w_done, 1'b0};
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_grant) w_state_nxt = ST_START; else w_state_nxt = ST_IDLE;
      ST_START:     w_state_nxt = ST_WAIT_BUSY;
      // Busy already high on entry advances immediately.
      ST_WAIT_BUSY: if (TX_BUSY) w_state_nxt = ST_WAIT_DONE; else w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_DONE: if (!TX_BUSY) w_state_nxt = ST_IDLE; else w_state_nxt = ST_WAIT_DONE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: start pulse decoded from the state register, ready from the grant
  always_comb begin
    w_tx_start  = 1'b0;
    w_dbg_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_dbg_ready = w_grant & w_sel_dbg;
      ST_START: w_tx_start  = 1'b1;
      default: begin
        w_tx_start  = 1'b0;
        w_dbg_ready = 1'b0;
      end
    endcase
  end

  // FIFO storage (no reset needed: validity is tracked by the count)
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= BUS_DI;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= L_PTR_ZERO;
      r_rd_ptr <= L_PTR_ZERO;
      r_count  <= L_CNT_ZERO;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Grant bookkeeping and the byte handed to the TX core
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rr_dbg_next <= 1'b1;
      r_last_dbg    <= 1'b0;
      r_tx_data     <= 8'h00;
    end else if (w_grant) begin
      r_rr_dbg_next <= ~w_sel_dbg;
      r_last_dbg    <= w_sel_dbg;
      r_tx_data     <= w_sel_dbg ? DBG_DATA : r_mem[r_rd_ptr];
    end
  end

  // Bus read data and sticky overflow flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bus_do <= 32'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (BUS_SEL & BUS_RD) begin
        r_bus_do <= BUS_OFS ? w_status : 32'd0;
      end
      // A new overflow beats the clear-on-read.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_stat_rd) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign BUS_DO    = r_bus_do;
  assign TX_DATA   = r_tx_data;
  assign TX_START  = w_tx_start;
  assign DBG_READY = w_dbg_ready;

endmodule

// File: tb/tb_uart0_tx_sched.sv
module tb_uart0_tx_sched;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BUS_SEL, BUS_WR, BUS_RD, BUS_OFS;
  logic [7:0]  BUS_DI;
  logic [31:0] BUS_DO;
  logic        DBG_VALID;
  logic [7:0]  DBG_DATA;
  logic        DBG_READY;
  logic        TX_START;
  logic [7:0]  TX_DATA;
  logic        TX_BUSY;

  uart0_tx_sched #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .BUS_SEL(BUS_SEL), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD), .BUS_OFS(BUS_OFS),
    .BUS_DI(BUS_DI), .BUS_DO(BUS_DO),
    .DBG_VALID(DBG_VALID), .DBG_DATA(DBG_DATA), .DBG_READY(DBG_READY),
    .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_BUSY(TX_BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue, transmitter phase, arbitration turn, flags
  logic [7:0]  m_q[$];
  bit          m_dbg_next;
  bit          m_last_dbg;
  bit          m_ovf;
  int          m_phase;      // 0 idle, 1 start, 2 wait busy, 3 wait done
  logic [7:0]  m_tx_data;
  logic [31:0] m_bus_do;
  logic [7:0]  exp_log[$];
  logic [7:0]  dut_log[$];
  int          n_start;

  // Stimulus agents: debug byte source and TX core
  logic [7:0] dbg_q[$];
  bit dbg_hold;
  bit force_busy, core_busy, core_pend;
  int lat, len, rc, hc;

  assign TX_BUSY = force_busy | core_busy;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dbg_next = 1'b1;
    m_last_dbg = 1'b0;
    m_ovf      = 1'b0;
    m_phase    = 0;
    m_tx_data  = 8'h00;
    m_bus_do   = 32'd0;
    exp_log.delete();
    dut_log.delete();
    dbg_q.delete();
    n_start    = 0;
    core_busy  = 1'b0;
    core_pend  = 1'b0;
    force_busy = 1'b0;
    dbg_hold   = 1'b0;
  endtask

  // One clock cycle: predict, advance, compare, then let the agents react
  task automatic step();
    logic [31:0] st;
    bit full, pc, gr, sd, rdy, pop, preq, ovs, rd, acc;
    if (dbg_q.size() > 0 && dbg_hold && ($urandom_range(0, 3) == 0)) void'(dbg_q.pop_front());
    DBG_VALID = (dbg_q.size() > 0) && !dbg_hold;
    DBG_DATA  = (dbg_q.size() > 0) ? dbg_q[0] : 8'h00;
    #1;
    full = (m_q.size() == DEPTH);
    st   = {27'd0, m_ovf, (m_phase != 0) && m_last_dbg, full,
            (m_q.size() == 0) && (m_phase == 0) && !DBG_VALID, 1'b0};
    pc   = (m_q.size() > 0);
    gr   = (m_phase == 0) && (pc || DBG_VALID);
    sd   = DBG_VALID && (!pc || m_dbg_next);
    rdy  = gr && sd;
    pop  = gr && !sd;
    chk("dbg_ready", DBG_READY, rdy);
    acc  = DBG_READY && DBG_VALID;
    preq = BUS_SEL && BUS_WR && !BUS_OFS;
    ovs  = preq && full && !pop;
    rd   = BUS_SEL && BUS_RD;
    if (rd) m_bus_do = BUS_OFS ? st : 32'd0;
    if (ovs) m_ovf = 1'b1;
    else if (rd && BUS_OFS) m_ovf = 1'b0;
    if (gr) begin
      if (sd) m_tx_data = DBG_DATA;
      else m_tx_data = m_q.pop_front();
      exp_log.push_back(m_tx_data);
      m_last_dbg = sd;
      m_dbg_next = !sd;
    end
    if (preq && !ovs) m_q.push_back(BUS_DI);
    case (m_phase)
      0: if (gr) m_phase = 1;
      1: m_phase = 2;
      2: if (TX_BUSY) m_phase = 3;
      default: if (!TX_BUSY) m_phase = 0;
    endcase
    @(posedge CLK);
    #1;
    if (acc) void'(dbg_q.pop_front());
    chk("tx_start", TX_START, (m_phase == 1));
    chk("tx_data", TX_DATA, m_tx_data);
    chk("bus_do", BUS_DO, m_bus_do);
    if (TX_START) begin
      dut_log.push_back(TX_DATA);
      n_start++;
    end
    if (TX_START) begin
      core_pend = 1'b1;
      rc = lat;
    end else if (core_pend) begin
      if (rc == 0) begin core_busy = 1'b1; core_pend = 1'b0; hc = len; end
      else rc--;
    end else if (core_busy) begin
      if (hc == 0) core_busy = 1'b0;
      else hc--;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(logic [7:0] b);
    BUS_SEL = 1'b1; BUS_WR = 1'b1; BUS_OFS = 1'b0; BUS_DI = b;
    step();
    BUS_SEL = 1'b0; BUS_WR = 1'b0;
  endtask

  task automatic rd(logic ofs);
    BUS_SEL = 1'b1; BUS_RD = 1'b1; BUS_OFS = ofs;
    step();
    BUS_SEL = 1'b0; BUS_RD = 1'b0; BUS_OFS = 1'b0;
  endtask

  task automatic wait_busy(logic lvl, int max);
    int n = 0;
    while (TX_BUSY !== lvl && n < max) begin step(); n++; end
    chk("wait_busy_bound", (TX_BUSY === lvl), 1);
  endtask

  task automatic drain(int max);
    int n = 0;
    dbg_hold = 1'b0;
    while ((m_q.size() > 0 || dbg_q.size() > 0 || m_phase != 0 || TX_BUSY || core_pend) && n < max) begin
      step();
      n++;
    end
    chk("drain_bound", (n < max), 1);
  endtask

  task automatic chk_log(string tag, input logic [7:0] e[$]);
    chk({tag, "_len"}, dut_log.size(), e.size());
    for (int i = 0; i < e.size() && i < dut_log.size(); i++) chk(tag, dut_log[i], e[i]);
  endtask

  // Asynchronous reset in the middle of a cycle
  task automatic async_reset(bit check_now);
    #3;
    RESET = 1'b1;
    BUS_SEL = 1'b0; BUS_WR = 1'b0; BUS_RD = 1'b0; BUS_OFS = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_tx_start", TX_START, 0);
      chk("rst_tx_data", TX_DATA, 0);
      chk("rst_bus_do", BUS_DO, 0);
      chk("rst_dbg_ready", DBG_READY, 0);
    end
    model_reset();
    DBG_VALID = 1'b0;
    #2;
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] e[$];
    RESET = 1'b1;
    BUS_SEL = 1'b0; BUS_WR = 1'b0; BUS_RD = 1'b0; BUS_OFS = 1'b0; BUS_DI = 8'h00;
    DBG_VALID = 1'b0; DBG_DATA = 8'h00;
    model_reset();
    lat = 1; len = 2; rc = 0; hc = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_tx_start", TX_START, 0);
    chk("reset_tx_data", TX_DATA, 0);
    chk("reset_bus_do", BUS_DO, 0);
    chk("reset_dbg_ready", DBG_READY, 0);
    #3;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    rd(1'b1);
    chk("status_after_reset", BUS_DO, 32'h0000_0002);

    // Single CPU byte
    lat = 2; len = 6;
    wr(8'h61);
    step();
    chk("first_start", TX_START, 1);
    chk("first_data", TX_DATA, 8'h61);
    wait_busy(1'b1, 20);
    rd(1'b1);
    chk("status_busy", BUS_DO, 32'h0000_0000);
    wait_busy(1'b0, 20);
    idle(1);
    rd(1'b1);
    chk("status_idle", BUS_DO, 32'h0000_0002);
    drain(50);

    // FIFO overflow while the TX core is held busy
    dut_log.delete();
    lat = 1; len = 2;
    force_busy = 1'b1;
    for (int b = 8'h41; b <= 8'h46; b++) wr(8'(b));
    rd(1'b1);
    chk("status_full_ovf", BUS_DO, 32'h0000_0014);
    rd(1'b1);
    chk("status_ovf_cleared", BUS_DO, 32'h0000_0004);
    force_busy = 1'b0;
    drain(200);
    e = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    chk_log("ovf_seq", e);

    // Round robin, debug first after reset
    async_reset(1'b0);
    lat = 1; len = 2;
    dbg_q.push_back(8'hA0);
    dbg_q.push_back(8'hA1);
    wr(8'h31);
    wr(8'h32);
    drain(200);
    e = '{8'hA0, 8'h31, 8'hA1, 8'h32};
    chk_log("rr_seq", e);

    // Reset in WAIT_DONE with three bytes queued
    force_busy = 1'b1;
    wr(8'h51); wr(8'h52); wr(8'h53); wr(8'h54);
    idle(2);
    chk("pre_reset_queued", m_q.size(), 3);
    async_reset(1'b1);
    idle(20);
    chk("no_start_after_reset", n_start, 0);
    rd(1'b1);
    chk("status_after_mid_reset", BUS_DO, 32'h0000_0002);

    // Randomised traffic with zero- and five-cycle busy latency
    for (int pass = 0; pass < 2; pass++) begin
      async_reset(1'b0);
      lat = (pass == 0) ? 0 : 5;
      len = (pass == 0) ? 1 : 4;
      for (int c = 0; c < 300; c++) begin
        dbg_hold = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) dbg_q.push_back(8'($urandom));
        case ($urandom_range(0, 5))
          0, 1: wr(8'($urandom));
          2: rd(1'($urandom));
          default: step();
        endcase
      end
      drain(2000);
      chk("rand_start_count", n_start, exp_log.size());
      chk_log("rand_seq", exp_log);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
